vx_mp_scoreboard: RTL

- Parametrised successor to the core's single-writeback scoreboard.
- Tracks in-flight destination registers per warp and gates issue on RAW/WAW hazards.
- Accepts up to WB_PORTS writebacks per cycle, with optional same-cycle clear bypass.
- Adds per-warp drain status, a saturating stall counter and a deadlock watchdog. Sits between the instruction buffer and dispatch in the issue stage.

---
 rtl/vx_issue_pkg.sv | 24 ++
 rtl/vx_pending_table.sv | 68 ++++++
 rtl/vx_mp_scoreboard.sv | 124 ++++++++++++
 3 files changed

// File: rtl/vx_issue_pkg.sv
// rtl/vx_issue_pkg.sv - shared issue-stage types, width helpers and constants
package vx_issue_pkg;

    localparam int MAX_WID_W = 8;
    localparam int MAX_REG_W = 8;
    localparam int REG_ZERO  = 0;

    function automatic int calc_wid_w(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    function automatic int calc_reg_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

    // Fields are sized for the largest supported configuration; users zero-extend.
    typedef struct packed {
        logic                 valid;
        logic [MAX_WID_W-1:0] wid;
        logic [MAX_REG_W-1:0] rd;
        logic                 eop;
    } wb_port_t;

endpackage

// File: rtl/vx_pending_table.sv
// rtl/vx_pending_table.sv - per-warp pending-register bit array, one set port, N clear ports
module vx_pending_table
    import vx_issue_pkg::*;
#(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 64,
    parameter int WB_PORTS  = 2,
    parameter int WID_W     = 2,
    parameter int REG_W     = 6
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 set_valid,
    input  logic [WID_W-1:0]                     set_wid,
    input  logic [REG_W-1:0]                     set_rd,
    input  wb_port_t [WB_PORTS-1:0]              clr_ports,
    output logic [NUM_WARPS-1:0][NUM_REGS-1:0]   pending,
    output logic [NUM_WARPS-1:0][NUM_REGS-1:0]   clr_mask,
    output logic [NUM_WARPS-1:0]                 warp_busy
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] set_mask;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (clr_ports[p].valid && clr_ports[p].eop &&
                        clr_ports[p].wid == MAX_WID_W'(w) &&
                        clr_ports[p].rd == MAX_REG_W'(r))
                        clr_mask[w][r] = 1'b1;
                end
                if (set_valid && set_wid == WID_W'(w) && set_rd == REG_W'(r))
                    set_mask[w][r] = 1'b1;
            end
        end
    end

    // Set is OR-ed in after the clear so a same-cycle set on a clearing entry wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end

    always_comb begin
        warp_busy = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            warp_busy[w] = |pending[w];
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (clr_ports[p].valid && clr_ports[p].eop)
                    assert (pending[clr_ports[p].wid[WID_W-1:0]][clr_ports[p].rd[REG_W-1:0]])
                    else $error("clear of non-pending entry wid=%0d rd=%0d",
                                clr_ports[p].wid, clr_ports[p].rd);
            end
        end
    end
`endif

endmodule

// File: rtl/vx_mp_scoreboard.sv
// rtl/vx_mp_scoreboard.sv - multi-writeback issue scoreboard with stall counter and watchdog
module vx_mp_scoreboard
    import vx_issue_pkg::*;
#(
    parameter  int NUM_WARPS       = 4,
    parameter  int NUM_REGS        = 64,
    parameter  int WB_PORTS        = 2,
    parameter  int BYPASS          = 0,
    parameter  int PERF_BITS       = 44,
    parameter  int DEADLOCK_CYCLES = 1000000,
    localparam int WID_W           = calc_wid_w(NUM_WARPS),
    localparam int REG_W           = calc_reg_w(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [WID_W-1:0]          issue_wid,
    input  logic                      issue_wb,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [REG_W-1:0]          issue_rs1,
    input  logic [REG_W-1:0]          issue_rs2,
    input  logic [REG_W-1:0]          issue_rs3,
    input  logic [2:0]                issue_use_rs,
    output logic                      issue_ready,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*WID_W-1:0] wb_wid,
    input  logic [WB_PORTS*REG_W-1:0] wb_rd,
    input  logic [WB_PORTS-1:0]       wb_eop,
    output logic [NUM_WARPS-1:0]      warp_busy,
    output logic [PERF_BITS-1:0]      stall_count,
    output logic                      deadlock
);

    localparam bit              BYP      = (BYPASS != 0);
    localparam int              WD_W     = $clog2(DEADLOCK_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DEADLOCK_CYCLES);
    localparam logic [REG_W-1:0] RZ      = REG_W'(REG_ZERO);

    wb_port_t [WB_PORTS-1:0]            wb_ports;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pending;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] clr_mask;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] eff;
    logic                               hazard;
    logic                               fire;
    logic                               stall;
    logic                               set_valid;
    logic [WD_W-1:0]                    wd_cnt;

    always_comb begin
        wb_ports = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_ports[p].valid = wb_valid[p];
            wb_ports[p].wid   = MAX_WID_W'(wb_wid[p*WID_W +: WID_W]);
            wb_ports[p].rd    = MAX_REG_W'(wb_rd[p*REG_W +: REG_W]);
            wb_ports[p].eop   = wb_eop[p];
        end
    end

    // With bypass, entries retiring this cycle no longer block issue.
    assign eff = BYP ? (pending & ~clr_mask) : pending;

    always_comb begin
        hazard = 1'b0;
        if (issue_wb && issue_rd != RZ && eff[issue_wid][issue_rd])
            hazard = 1'b1;
        if (issue_use_rs[0] && issue_rs1 != RZ && eff[issue_wid][issue_rs1])
            hazard = 1'b1;
        if (issue_use_rs[1] && issue_rs2 != RZ && eff[issue_wid][issue_rs2])
            hazard = 1'b1;
        if (issue_use_rs[2] && issue_rs3 != RZ && eff[issue_wid][issue_rs3])
            hazard = 1'b1;
    end

    assign issue_ready = !hazard;
    assign fire        = issue_valid && issue_ready;
    assign stall       = issue_valid && !issue_ready;
    assign set_valid   = fire && issue_wb && (issue_rd != RZ);

    vx_pending_table #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS),
        .WB_PORTS  (WB_PORTS),
        .WID_W     (WID_W),
        .REG_W     (REG_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .set_valid (set_valid),
        .set_wid   (issue_wid),
        .set_rd    (issue_rd),
        .clr_ports (wb_ports),
        .pending   (pending),
        .clr_mask  (clr_mask),
        .warp_busy (warp_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Once tripped the count freezes; only a fire (or reset) re-arms the watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt   <= '0;
            deadlock <= 1'b0;
        end else if (fire) begin
            wd_cnt   <= '0;
            deadlock <= 1'b0;
        end else if (!deadlock) begin
            if (stall) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt + 1'b1 == WD_LIMIT)
                    deadlock <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule
